pc_fetch_stage: RTL and testbench

Holds the architectural program counter and drives the instruction-memory fetch request. Consumes the next-sequential address produced by the PC adder, which is wired a = pc_o, b = 32'd4. Applies branch/jump redirects, pipeline stalls and flushes, and registers the fetched instruction into the IF/ID pipeline register for decode. Sits between the PC adder, instruction memory and the decode stage.

---
 rtl/pc_fetch_stage.sv | 109 ++++++++++
 tb/tb_pc_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: program counter, instruction fetch request and IF/ID pipeline register.
// Ports:
//   clk, rst_n                     clock and asynchronous active-low reset
//   pc_o / imem_addr_o             current PC, feeds the external PC adder and instruction memory
//   pc_plus4_i                     PC adder result (pc_o + 4)
//   redirect_valid_i/redirect_pc_i branch/jump redirect from EX
//   stall_i, flush_i               hazard stall and IF/ID squash
//   imem_req_o, imem_ready_i,
//   imem_rdata_i                   instruction memory request/response
//   if_id_*                        IF/ID register towards decode
//   misalign_o                     pulse after a redirect target with nonzero bits[1:0]
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] pc_plus4_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic [31:0] if_id_instr_o,
    output logic        misalign_o
);
    typedef enum logic [1:0] {BOOT, RUN, KILL} state_t;
    state_t      r_state;
    logic [31:0] r_pc, r_tgt, r_if_pc, r_if_pc4, r_if_instr;
    logic        r_if_valid, r_req, r_misalign;
    logic [31:0] w_tgt;
    assign w_tgt         = {redirect_pc_i[31:2], 2'b00};
    assign pc_o          = r_pc;
    assign imem_addr_o   = r_pc;
    assign imem_req_o    = r_req;
    assign if_id_valid_o = r_if_valid;
    assign if_id_pc_o    = r_if_pc;
    assign if_id_pc4_o   = r_if_pc4;
    assign if_id_instr_o = r_if_instr;
    assign misalign_o    = r_misalign;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_tgt      <= 32'h0;
            r_req      <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'h0;
            r_if_pc4   <= 32'h0;
            r_if_instr <= NOP_INSTR;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
            case (r_state)
                BOOT: begin
                    if (redirect_valid_i) r_pc <= w_tgt;
                    r_state <= RUN;
                    r_req   <= 1'b1;
                end
                RUN: begin
                    if (redirect_valid_i && !imem_ready_i) begin
                        // request in flight for the old PC: remember target until its response drains
                        r_tgt      <= w_tgt;
                        r_state    <= KILL;
                        r_if_valid <= 1'b0;
                        r_if_instr <= NOP_INSTR;
                    end else if (redirect_valid_i) begin
                        r_pc       <= w_tgt;
                        r_if_valid <= 1'b0;
                        r_if_instr <= NOP_INSTR;
                    end else if (flush_i) begin
                        if (imem_ready_i) r_pc <= pc_plus4_i;
                        r_if_valid <= 1'b0;
                        r_if_instr <= NOP_INSTR;
                    end else if (stall_i) begin
                        // hold everything; a response now is simply refetched from the same PC
                    end else if (imem_ready_i) begin
                        r_if_valid <= 1'b1;
                        r_if_pc    <= r_pc;
                        r_if_pc4   <= pc_plus4_i;
                        r_if_instr <= imem_rdata_i;
                        r_pc       <= pc_plus4_i;
                    end else begin
                        r_if_valid <= 1'b0;
                        r_if_instr <= NOP_INSTR;
                    end
                end
                KILL: begin
                    r_if_valid <= 1'b0;
                    r_if_instr <= NOP_INSTR;
                    if (imem_ready_i) begin
                        r_pc    <= redirect_valid_i ? w_tgt : r_tgt;
                        r_state <= RUN;
                    end else if (redirect_valid_i) begin
                        r_tgt <= w_tgt;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed and randomized checks of pc_fetch_stage against a reference model.
module tb_pc_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_o, pc_plus4_i, redirect_pc_i, imem_addr_o, imem_rdata_i;
    logic [31:0] if_id_pc_o, if_id_pc4_o, if_id_instr_o;
    logic        redirect_valid_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, imem_ready_i = 1'b0;
    logic        imem_req_o, if_id_valid_o, misalign_o;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    assign pc_plus4_i   = pc_o + 32'd4;
    assign imem_rdata_i = mem(imem_addr_o);

    pc_fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .pc_plus4_i(pc_plus4_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .stall_i(stall_i), .flush_i(flush_i), .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
        .if_id_valid_o(if_id_valid_o), .if_id_pc_o(if_id_pc_o), .if_id_pc4_o(if_id_pc4_o),
        .if_id_instr_o(if_id_instr_o), .misalign_o(misalign_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        redirect_pc_i = 32'h0; imem_ready_i = 1'b1; rst_n = 1'b0;
        tick(); tick();
        n_tests++;
        if (pc_o !== 32'h0 || imem_req_o !== 1'b0 || if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP ||
            if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0 || misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vals: pc=%h req=%b valid=%b instr=%h ifpc=%h ifpc4=%h mis=%b, want all reset values",
                     pc_o, imem_req_o, if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o, misalign_o);
        end
        rst_n = 1'b1;
        n_tests++;
        if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b want 0", imem_req_o); end
        tick();
        n_tests++;
        if (pc_o !== 32'h0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL run_first: pc=%h req=%b addr=%h want 0/1/0", pc_o, imem_req_o, imem_addr_o);
        end
        tick();
        n_tests++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h4 ||
            if_id_instr_o !== 32'h0050_0093 || pc_o !== 32'h4) begin
            n_fail++;
            $display("FAIL first_fetch: valid=%b ifpc=%h ifpc4=%h instr=%h pc=%h want 1/0/4/00500093/4",
                     if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, pc_o);
        end
    endtask

    task automatic test_stream_stall;
        tick();
        n_tests++;
        if (pc_o !== 32'h8 || if_id_pc_o !== 32'h4) begin
            n_fail++; $display("FAIL stream: pc=%h ifpc=%h want 8/4", pc_o, if_id_pc_o);
        end
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (pc_o !== 32'h8 || if_id_pc_o !== 32'h4 || if_id_valid_o !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold: pc=%h ifpc=%h valid=%b want 8/4/1", pc_o, if_id_pc_o, if_id_valid_o);
            end
        end
        stall_i = 1'b0;
        tick();
        n_tests++;
        if (if_id_pc_o !== 32'h8 || if_id_instr_o !== mem(32'h8) || pc_o !== 32'hC) begin
            n_fail++; $display("FAIL stall_release: ifpc=%h instr=%h pc=%h want 8/%h/c", if_id_pc_o, if_id_instr_o, pc_o, mem(32'h8));
        end
        tick();
        n_tests++;
        if (if_id_pc_o !== 32'hC || pc_o !== 32'h10) begin
            n_fail++; $display("FAIL stream_next: ifpc=%h pc=%h want c/10", if_id_pc_o, pc_o);
        end
    endtask

    task automatic test_redirect_ready;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        redirect_valid_i = 1'b0;
        n_tests++;
        if (pc_o !== 32'h100 || if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP || misalign_o !== 1'b0) begin
            n_fail++; $display("FAIL redir_ready: pc=%h valid=%b instr=%h mis=%b want 100/0/13/0", pc_o, if_id_valid_o, if_id_instr_o, misalign_o);
        end
        tick();
        n_tests++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h100 || if_id_pc4_o !== 32'h104 || pc_o !== 32'h104) begin
            n_fail++; $display("FAIL redir_deliver: valid=%b ifpc=%h ifpc4=%h pc=%h want 1/100/104/104", if_id_valid_o, if_id_pc_o, if_id_pc4_o, pc_o);
        end
    endtask

    task automatic test_redirect_wait;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h20;
        tick();
        imem_ready_i = 1'b0; redirect_pc_i = 32'h80;
        tick();
        redirect_valid_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (pc_o !== 32'h20 || imem_req_o !== 1'b1 || if_id_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL kill_hold: pc=%h req=%b valid=%b want 20/1/0", pc_o, imem_req_o, if_id_valid_o);
            end
            stall_i = 1'b1; flush_i = 1'b1;
            tick();
        end
        stall_i = 1'b0; flush_i = 1'b0; imem_ready_i = 1'b1;
        tick();
        n_tests++;
        if (pc_o !== 32'h80 || if_id_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL kill_drop: pc=%h valid=%b want 80/0", pc_o, if_id_valid_o);
        end
        tick();
        n_tests++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h80 || if_id_instr_o !== mem(32'h80)) begin
            n_fail++; $display("FAIL kill_resume: valid=%b ifpc=%h instr=%h want 1/80/%h", if_id_valid_o, if_id_pc_o, if_id_instr_o, mem(32'h80));
        end
    endtask

    task automatic test_misalign_wrap;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h102;
        tick();
        redirect_valid_i = 1'b0;
        n_tests++;
        if (pc_o !== 32'h100 || misalign_o !== 1'b1) begin
            n_fail++; $display("FAIL misalign_pulse: pc=%h mis=%b want 100/1", pc_o, misalign_o);
        end
        tick();
        n_tests++;
        if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b want 0", misalign_o); end
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_valid_i = 1'b0;
        tick();
        n_tests++;
        if (if_id_pc_o !== 32'hFFFF_FFFC || if_id_pc4_o !== 32'h0 || pc_o !== 32'h0 || if_id_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL wrap: ifpc=%h ifpc4=%h pc=%h valid=%b want fffffffc/0/0/1", if_id_pc_o, if_id_pc4_o, pc_o, if_id_valid_o);
        end
    endtask

    task automatic test_async_reset_kill;
        imem_ready_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        redirect_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (pc_o !== 32'h0 || imem_req_o !== 1'b0 || if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP ||
            if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0 || misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pc=%h req=%b valid=%b instr=%h ifpc=%h ifpc4=%h mis=%b, want reset values",
                     pc_o, imem_req_o, if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o, misalign_o);
        end
        tick();
        rst_n = 1'b1; imem_ready_i = 1'b1;
        tick();
        n_tests++;
        if (pc_o !== 32'h0 || imem_req_o !== 1'b1) begin
            n_fail++; $display("FAIL reboot: pc=%h req=%b want 0/1", pc_o, imem_req_o);
        end
        tick();
        n_tests++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0 || pc_o !== 32'h4) begin
            n_fail++; $display("FAIL reboot_fetch: valid=%b ifpc=%h pc=%h want 1/0/4", if_id_valid_o, if_id_pc_o, pc_o);
        end
    endtask

    task automatic test_random;
        logic        m_boot, m_valid, m_mis, rv, rdy, st, fl;
        logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, rpc, tgt;
        logic [31:0] kill_q[$];
        rst_n = 1'b0; redirect_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        tick();
        rst_n = 1'b1;
        m_boot = 1'b1; m_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
        m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = NOP; kill_q.delete();
        for (int c = 0; c < 3000; c++) begin
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            st  = ($urandom_range(0, 6) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : ($urandom & 32'h0000_0FFF);
            redirect_valid_i = rv; imem_ready_i = rdy; stall_i = st; flush_i = fl; redirect_pc_i = rpc;
            tick();
            tgt   = rpc & 32'hFFFF_FFFC;
            m_mis = rv && (rpc[1:0] != 2'b00);
            if (m_boot) begin
                if (rv) m_pc = tgt;
                m_boot = 1'b0;
            end else if (kill_q.size() != 0) begin
                m_valid = 1'b0; m_instr = NOP;
                if (rdy) begin
                    m_pc = rv ? tgt : kill_q[0];
                    kill_q.delete();
                end else if (rv) kill_q[0] = tgt;
            end else if (rv) begin
                m_valid = 1'b0; m_instr = NOP;
                if (rdy) m_pc = tgt; else kill_q.push_back(tgt);
            end else if (fl) begin
                m_valid = 1'b0; m_instr = NOP;
                if (rdy) m_pc = m_pc + 32'd4;
            end else if (st) begin
            end else if (rdy) begin
                m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = mem(m_pc);
                m_pc = m_pc + 32'd4;
            end else begin
                m_valid = 1'b0; m_instr = NOP;
            end
            n_tests++;
            if (pc_o !== m_pc || imem_addr_o !== m_pc || imem_req_o !== 1'b1 || if_id_valid_o !== m_valid ||
                if_id_instr_o !== m_instr || misalign_o !== m_mis ||
                (m_valid && (if_id_pc_o !== m_ipc || if_id_pc4_o !== m_ipc4))) begin
                n_fail++;
                $display("FAIL random cycle %0d: pc=%h req=%b valid=%b ifpc=%h ifpc4=%h instr=%h mis=%b want pc=%h req=1 valid=%b ifpc=%h ifpc4=%h instr=%h mis=%b",
                         c, pc_o, imem_req_o, if_id_valid_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, misalign_o,
                         m_pc, m_valid, m_ipc, m_ipc4, m_instr, m_mis);
            end
        end
        redirect_valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream_stall();
        test_redirect_ready();
        test_redirect_wait();
        test_misalign_wrap();
        test_async_reset_kill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
